fetch_unit: RTL and testbench

Instruction fetch stage feeding the microprogrammed control unit. Owns the fetch PC, issues word reads to instruction memory over a single-outstanding request/valid handshake, and buffers returned words in a small prefetch queue. Presents the head instruction as the instruction register, with opcode = ir[15:11], to the control unit. Handles control-unit redirects (jump taken, call, ret) by flushing the queue and discarding stale in-flight data.

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_queue.sv | 47 ++++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Build option FETCH_PREFETCH_EN: 2-entry prefetch queue with run-ahead; otherwise 1 entry, fetch on demand.
package fetch_unit_pkg;

  localparam int INSTR_SIZE     = 16;
  localparam int OPCODE_HI      = 15;
  localparam int OPCODE_LO      = 11;
  localparam int DEFAULT_ADDR_W = 10;

`ifdef FETCH_PREFETCH_EN
  localparam int QUEUE_DEPTH = 2;
`else
  localparam int QUEUE_DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  function automatic logic [OPCODE_HI-OPCODE_LO:0] opcode_of(input logic [INSTR_SIZE-1:0] word);
    return word[OPCODE_HI:OPCODE_LO];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small shift-register FIFO of {instruction word, pc}; entry 0 is always the head.
// Flush has priority over push and pop.
module fetch_queue #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[0];

  // Only live entries shift down, so a drained queue keeps presenting its last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      for (int i = 0; i + 1 < DEPTH; i++)
        if (pop_ok && (i + 1 < int'(count))) mem[i] <= mem[i+1];
      for (int i = 0; i < DEPTH; i++)
        if (push_ok && (i == int'(count) - (pop_ok ? 1 : 0))) mem[i] <= din;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, single-outstanding imem reads, prefetch queue and redirects.
// Queue depth follows FETCH_PREFETCH_EN (see fetch_unit_pkg).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_W-1:0]     imem_addr,
  input  logic                  imem_valid,
  input  logic [INSTR_SIZE-1:0] imem_data,
  output logic                  ir_valid,
  output logic [INSTR_SIZE-1:0] ir,
  output logic [ADDR_W-1:0]     ir_pc,
  input  logic                  ir_take,
  input  logic                  redirect,
  input  logic [ADDR_W-1:0]     redirect_addr
);

  localparam int QW = INSTR_SIZE + ADDR_W;

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic              issue;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [QW-1:0]     head;

  // imem_req is decoded from the state register only, so imem_valid never reaches it combinationally.
  assign imem_req    = (state != IDLE);
  assign pop         = ir_take && !empty && !redirect;
  assign ir_valid    = !empty;
  assign {ir, ir_pc} = head;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!redirect && !full) begin
          state_nxt = WAIT;
          issue     = 1'b1;
        end
      end
      WAIT: begin
        if (imem_valid) begin
          state_nxt = IDLE;
          push      = !redirect;
        end else if (redirect) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      imem_addr <= '0;
    end else begin
      if (redirect)  fetch_pc <= redirect_addr;
      else if (push) fetch_pc <= fetch_pc + ADDR_W'(1);
      if (issue) imem_addr <= fetch_pc;
    end
  end

  fetch_queue #(
    .DEPTH  (QUEUE_DEPTH),
    .DATA_W (QW)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({imem_data, imem_addr}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: program-order scoreboard, directed sequences, vector table, random traffic.
module tb_fetch_unit;

  localparam int ADDR_W = 10;
`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam int K_REQ_HI = 0;
  localparam int K_REQ_LO = 1;
  localparam int K_IRV    = 2;
  localparam int K_SIMUL  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, imem_req, imem_valid, ir_valid, ir_take, redirect;
  logic [ADDR_W-1:0] imem_addr, ir_pc, redirect_addr;
  logic [15:0]       imem_data, ir;

  logic              imem_req_w, imem_valid_w, ir_valid_w;
  logic [ADDR_W-1:0] imem_addr_w, ir_pc_w;
  logic [15:0]       imem_data_w, ir_w;

  logic [15:0] mem [1 << ADDR_W];
  int errors = 0;
  int checks = 0;
  int lat = 1;

  fetch_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .ir_valid(ir_valid),
    .ir(ir), .ir_pc(ir_pc), .ir_take(ir_take), .redirect(redirect),
    .redirect_addr(redirect_addr)
  );

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(10'h3FF)) dut_w (
    .clk(clk), .rst(rst), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_valid(imem_valid_w), .imem_data(imem_data_w), .ir_valid(ir_valid_w),
    .ir(ir_w), .ir_pc(ir_pc_w), .ir_take(1'b1), .redirect(1'b0),
    .redirect_addr(10'h000)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, expected event within bound", name);
  endtask

  // Instruction memory with programmable latency; forgets any request on reset.
  bit                mbusy;
  int                mcnt;
  logic [ADDR_W-1:0] maddr;
  always @(posedge clk) begin
    if (rst) begin
      mbusy <= 1'b0; mcnt <= 0; imem_valid <= 1'b0;
    end else if (imem_valid) begin
      imem_valid <= 1'b0; mbusy <= 1'b0;
    end else if (mbusy) begin
      if (mcnt <= 1) begin imem_valid <= 1'b1; imem_data <= mem[maddr]; end
      else mcnt <= mcnt - 1;
    end else if (imem_req) begin
      mbusy <= 1'b1; mcnt <= lat; maddr <= imem_addr;
    end
  end

  always @(posedge clk) begin
    if (rst) imem_valid_w <= 1'b0;
    else if (imem_valid_w) imem_valid_w <= 1'b0;
    else if (imem_req_w) begin imem_valid_w <= 1'b1; imem_data_w <= mem[imem_addr_w]; end
  end

  // Reference model: the presented stream is the program in address order from the last redirect,
  // and the number of buffered words is wanted responses minus pops.
  logic [ADDR_W-1:0] exp_pc, prev_addr;
  int                buffered, issues, pops;
  bit                wanted, prev_req;
  always @(negedge clk) begin
    if (rst) begin
      exp_pc = '0; buffered = 0; wanted = 1'b0; prev_req = 1'b0; issues = 0;
    end else begin
      check("ir_valid_vs_model", 32'(ir_valid), 32'(buffered > 0));
      if (imem_req && !prev_req) begin
        issues++;
        wanted = 1'b1;
        check("credit_at_issue", 32'(buffered < DEPTH), 32'd1);
      end
      if (imem_req && prev_req) check("imem_addr_stable", 32'(imem_addr), 32'(prev_addr));
      prev_req  = imem_req;
      prev_addr = imem_addr;
      if (redirect) begin
        exp_pc = redirect_addr; buffered = 0; wanted = 1'b0;
      end else begin
        if (ir_take && ir_valid) begin
          check("stream_ir_pc", 32'(ir_pc), 32'(exp_pc));
          check("stream_ir", 32'(ir), 32'(mem[exp_pc]));
          exp_pc = exp_pc + 10'd1;
          buffered--;
          pops++;
        end
        if (imem_valid && wanted) begin buffered++; wanted = 1'b0; end
      end
    end
  end

  logic [ADDR_W-1:0] wexp;
  logic [ADDR_W-1:0] wrap_pc [2];
  int                wseen = 0;
  always @(negedge clk) begin
    if (rst) wexp = 10'h3FF;
    else if (ir_valid_w) begin
      check("wrap_stream_pc", 32'(ir_pc_w), 32'(wexp));
      check("wrap_stream_ir", 32'(ir_w), 32'(mem[wexp]));
      if (wseen < 2) wrap_pc[wseen] = ir_pc_w;
      wseen++;
      wexp = wexp + 10'd1;
    end
  end

  function automatic bit cond(input int kind);
    case (kind)
      K_REQ_HI: return imem_req;
      K_REQ_LO: return !imem_req;
      K_IRV:    return ir_valid;
      K_SIMUL:  return imem_valid && (ir_valid || DEPTH == 1);
      default:  return 1'b1;
    endcase
  endfunction

  task automatic wait_until(input int kind, input string name);
    int n = 0;
    while (!cond(kind)) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin timeout_fail(name); return; end
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                lat;
    logic [ADDR_W-1:0] pc0;
    logic [ADDR_W-1:0] pc1;
  } vec_t;
  vec_t vecs [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [ADDR_W-1:0] stale;
    int n;
    vecs[0] = '{10'h080, 3, 10'h080, 10'h081};
    vecs[1] = '{10'h3FF, 1, 10'h3FF, 10'h000};
    vecs[2] = '{10'h155, 2, 10'h155, 10'h156};
    vecs[3] = '{10'h001, 1, 10'h001, 10'h002};
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'($urandom);
    pops = 0;
    rst = 1'b1; ir_take = 1'b0; redirect = 1'b0; redirect_addr = '0; lat = 1;

    // Reset values, then first request
    repeat (3) @(posedge clk);
    #1;
    check("reset_imem_req", 32'(imem_req), 32'd0);
    check("reset_imem_addr", 32'(imem_addr), 32'd0);
    check("reset_ir_valid", 32'(ir_valid), 32'd0);
    check("reset_ir", 32'(ir), 32'd0);
    check("reset_ir_pc", 32'(ir_pc), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("req_after_reset", 32'(imem_req), 32'd1);
    check("addr_after_reset", 32'(imem_addr), 32'd0);

    // Backpressure: exactly DEPTH words fetched, then idle until one is taken
    repeat (40) @(posedge clk);
    #1;
    check("bp_issues", 32'(issues), 32'(DEPTH));
    check("bp_req_idle", 32'(imem_req), 32'd0);
    check("bp_head_pc", 32'(ir_pc), 32'd0);
    ir_take = 1'b1;
    @(posedge clk); #1;
    ir_take = 1'b0;
    wait_until(K_REQ_HI, "bp_new_req");
    check("bp_next_addr", 32'(imem_addr), 32'(DEPTH));

    // Streaming from reset with ir_take held high
    do_reset(2);
    ir_take = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_until(K_IRV, "stream_wait");
      check("stream_seq_pc", 32'(ir_pc), 32'(k));
      check("stream_seq_ir", 32'(ir), 32'(mem[k]));
      @(posedge clk); #1;
    end

    // Redirect while a slow request is outstanding
    lat = 3;
    wait_until(K_REQ_LO, "rw_req_low");
    wait_until(K_REQ_HI, "rw_req_high");
    stale = imem_addr;
    redirect = 1'b1; redirect_addr = 10'h080;
    @(posedge clk); #1;
    redirect = 1'b0;
    n = 0;
    while (!imem_valid && n < 20) begin
      check("rw_addr_held", 32'(imem_addr), 32'(stale));
      check("rw_req_held", 32'(imem_req), 32'd1);
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) timeout_fail("rw_stale_valid");
    check("rw_addr_at_stale_valid", 32'(imem_addr), 32'(stale));
    wait_until(K_REQ_LO, "rw_drop_done");
    wait_until(K_REQ_HI, "rw_new_req");
    check("rw_new_addr", 32'(imem_addr), 32'h080);
    wait_until(K_IRV, "rw_ir");
    check("rw_ir_pc", 32'(ir_pc), 32'h080);
    check("rw_ir", 32'(ir), 32'(mem[10'h080]));

    // redirect + ir_take + imem_valid in one cycle
    lat = 1; ir_take = 1'b0;
    do_reset(2);
    wait_until(K_SIMUL, "sim_setup");
    ir_take = 1'b1; redirect = 1'b1; redirect_addr = 10'h200;
    @(posedge clk); #1;
    ir_take = 1'b0; redirect = 1'b0;
    check("sim_ir_valid", 32'(ir_valid), 32'd0);
    check("sim_idle", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    check("sim_req", 32'(imem_req), 32'd1);
    check("sim_addr", 32'(imem_addr), 32'h200);

    // Reset while a request is outstanding
    lat = 3;
    wait_until(K_REQ_HI, "rmid_req");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rmid_req", 32'(imem_req), 32'd0);
    check("rmid_ir_valid", 32'(ir_valid), 32'd0);
    ir_take = 1'b1;
    wait_until(K_REQ_HI, "rmid_new_req");
    check("rmid_addr", 32'(imem_addr), 32'd0);

    // Vector table: redirect target, latency, next two presented pcs
    foreach (vecs[i]) begin
      lat = vecs[i].lat;
      ir_take = 1'b1;
      redirect = 1'b1; redirect_addr = vecs[i].addr;
      @(posedge clk); #1;
      redirect = 1'b0;
      check("vec_flush", 32'(ir_valid), 32'd0);
      for (int k = 0; k < 2; k++) begin
        wait_until(K_IRV, "vec_wait");
        check("vec_ir_pc", 32'(ir_pc), 32'((k == 0) ? vecs[i].pc0 : vecs[i].pc1));
        check("vec_ir", 32'(ir), 32'(mem[(k == 0) ? vecs[i].pc0 : vecs[i].pc1]));
        @(posedge clk); #1;
      end
    end

    // Random traffic against the scoreboard
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) lat = int'($urandom_range(1, 3));
      ir_take       = ($urandom_range(0, 3) != 0);
      redirect      = ($urandom_range(0, 49) == 0);
      redirect_addr = 10'($urandom);
      @(posedge clk); #1;
    end
    redirect = 1'b0; ir_take = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    check("random_activity", 32'(pops > 100), 32'd1);
    check("wrap_seen", 32'(wseen >= 2), 32'd1);
    check("wrap_first_pc", 32'(wrap_pc[0]), 32'h3FF);
    check("wrap_second_pc", 32'(wrap_pc[1]), 32'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
